fx68k_clkgen: RTL and testbench

Clock-enable and reset sequencer for the fx68k core. Divides the single system clock into the two CPU phase strobes (enPhi1, enPhi2) and generates the power-up and external reset levels, delivering them as one packed s_clks struct. Sits directly upstream of the core; every sequential element in the core qualifies on these enables.

---
 rtl/fx68k_clkgen.sv | 139 +++++++++++++
 tb/tb_fx68k_clkgen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx68k_clkgen.sv
// Clock-enable and reset sequencer for the fx68k core: phase strobes, power-up and external reset levels.
// Optional minimum-width reset stretching is built when FX68K_RESET_STRETCH_EN is defined.

package fx68k_clkgen_pkg;
    typedef struct packed {
        logic extReset;
        logic pwrUp;
        logic enPhi1;
        logic enPhi2;
    } s_clks;
endpackage

module fx68k_clkgen
    import fx68k_clkgen_pkg::*;
#(
    parameter int DIV          = 4,
    parameter int PWRUP_CYCLES = 512,
    parameter int RESET_MIN    = 132
) (
    input  logic  clk,
    input  logic  extReset,
    input  logic  sysResetReq,
    input  logic  clkStall,
    output s_clks clks,
    output logic  cpuPhase
);

    localparam int CW = $clog2(DIV);
    localparam int PW = $clog2(PWRUP_CYCLES + 1);
    localparam logic [CW-1:0] PHI2_AT = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] PHI1_AT = CW'(DIV - 1);
    localparam logic [PW-1:0] PWRUP_LAST = PW'(PWRUP_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          en_phi1_q;
    logic          en_phi2_q;
    logic          phi1_nxt;
    logic          phi2_nxt;
    logic          phase_q;
    logic          phase_nxt;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_nxt;
    logic          pwrup_q;
    logic          pwrup_nxt;
    logic          req_nxt;
    logic          ext_reset_q;

    // Strobes are decided from the current count so each lands one clk after the advancing edge.
    always_comb begin
        cnt_nxt   = cnt_q;
        phi1_nxt  = 1'b0;
        phi2_nxt  = 1'b0;
        phase_nxt = phase_q;
        if (!clkStall) begin
            cnt_nxt = (cnt_q == PHI1_AT) ? '0 : cnt_q + 1'b1;
            if (cnt_q == PHI2_AT) begin
                phi2_nxt  = 1'b1;
                phase_nxt = 1'b1;
            end
            if (cnt_q == PHI1_AT) begin
                phi1_nxt  = 1'b1;
                phase_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        pcnt_nxt  = pcnt_q;
        pwrup_nxt = pwrup_q;
        if (pwrup_q && en_phi1_q) begin
            pcnt_nxt = pcnt_q + 1'b1;
            if (pcnt_q == PWRUP_LAST) begin
                pwrup_nxt = 1'b0;
            end
        end
    end

`ifdef FX68K_RESET_STRETCH_EN
    localparam int SW = $clog2(RESET_MIN + 1);

    logic [SW-1:0] scnt_q;
    logic [SW-1:0] scnt_nxt;

    // Held request keeps reloading; the count only drains on CPU clocks, so a stall pauses it.
    always_comb begin
        scnt_nxt = scnt_q;
        if (sysResetReq) begin
            scnt_nxt = SW'(RESET_MIN);
        end else if (en_phi1_q && (scnt_q != '0)) begin
            scnt_nxt = scnt_q - 1'b1;
        end
        req_nxt = sysResetReq | (scnt_nxt != '0);
    end

    always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_nxt;
        end
    end
`else
    always_comb begin
        req_nxt = sysResetReq;
    end
`endif

    always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
            cnt_q       <= '0;
            en_phi1_q   <= 1'b0;
            en_phi2_q   <= 1'b0;
            phase_q     <= 1'b0;
            pcnt_q      <= '0;
            pwrup_q     <= 1'b1;
            ext_reset_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_nxt;
            en_phi1_q   <= phi1_nxt;
            en_phi2_q   <= phi2_nxt;
            phase_q     <= phase_nxt;
            pcnt_q      <= pcnt_nxt;
            pwrup_q     <= pwrup_nxt;
            ext_reset_q <= pwrup_nxt | req_nxt;
        end
    end

    always_comb begin
        clks.extReset = ext_reset_q;
        clks.pwrUp    = pwrup_q;
        clks.enPhi1   = en_phi1_q;
        clks.enPhi2   = en_phi2_q;
        cpuPhase      = phase_q;
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (extReset) !(en_phi1_q && en_phi2_q));

endmodule

// File: tb/tb_fx68k_clkgen.sv
// Directed bench for fx68k_clkgen: DIV=4 instance for power-up/reset-request, DIV=6 instance for stall.
// Expected reset-request timing follows FX68K_RESET_STRETCH_EN in the same way as the design.

module tb_fx68k_clkgen;
    import fx68k_clkgen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst;
    logic  req_a, stall_a, req_b, stall_b;
    s_clks clks_a, clks_b;
    logic  phase_a, phase_b;
    logic [3:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    assign obs_a = clks_a;
    assign obs_b = clks_b;

    fx68k_clkgen #(.DIV(4), .PWRUP_CYCLES(8), .RESET_MIN(4)) dut_a (
        .clk(clk), .extReset(rst), .sysResetReq(req_a), .clkStall(stall_a),
        .clks(clks_a), .cpuPhase(phase_a)
    );

    fx68k_clkgen #(.DIV(6), .PWRUP_CYCLES(512), .RESET_MIN(4)) dut_b (
        .clk(clk), .extReset(rst), .sysResetReq(req_b), .clkStall(stall_b),
        .clks(clks_b), .cpuPhase(phase_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_a = 1'b0; stall_a = 1'b0;
        req_b = 1'b0; stall_b = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_a = 1'b0; stall_a = 1'b0;
        req_b = 1'b0; stall_b = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_a !== 4'b1100 || phase_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_a step %0d got clks=%b phase=%b expected clks=1100 phase=0", i, obs_a, phase_a);
            end
            checks++;
            if (obs_b !== 4'b1100 || phase_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_b step %0d got clks=%b phase=%b expected clks=1100 phase=0", i, obs_b, phase_b);
            end
            stall_a = (i == 1);
            req_a = (i == 1);
            tick;
        end
    endtask

    task automatic test_powerup;
        logic [3:0] exp;
        logic       exp_ph;
        do_reset;
        for (int c = 1; c <= 40; c++) begin
            tick;
            exp = {c < 33, c < 33, (c % 4) == 0, (c % 4) == 2};
            exp_ph = (c >= 2) && ((c % 4) >= 2);
            checks++;
            if (obs_a !== exp || phase_a !== exp_ph) begin
                errors++;
                $display("FAIL powerup cycle %0d got clks=%b phase=%b expected clks=%b phase=%b", c, obs_a, phase_a, exp, exp_ph);
            end
        end
    endtask

    // Continues from cycle 40 of test_powerup.
    task automatic test_reset_request;
        logic [3:0] exp;
        logic       exp_ext;
        for (int c = 41; c <= 60; c++) begin
            tick;
`ifdef FX68K_RESET_STRETCH_EN
            exp_ext = (c >= 42) && (c <= 56);
`else
            exp_ext = (c >= 42) && (c <= 44);
`endif
            exp = {exp_ext, 1'b0, (c % 4) == 0, (c % 4) == 2};
            checks++;
            if (obs_a !== exp || phase_a !== ((c % 4) >= 2)) begin
                errors++;
                $display("FAIL reset_request cycle %0d got clks=%b phase=%b expected clks=%b phase=%b", c, obs_a, phase_a, exp, (c % 4) >= 2);
            end
`ifdef FX68K_RESET_STRETCH_EN
            req_a = (c + 1 == 42);
`else
            req_a = (c + 1 >= 42) && (c + 1 <= 44);
`endif
        end
    endtask

    // Continues from cycle 60: request pulse coinciding with a 6-clk stall.
    task automatic test_req_stall;
        logic [3:0] exp;
        logic       exp_ext;
        logic       exp_ph;
        int         t;
        for (int c = 61; c <= 86; c++) begin
            tick;
            t = (c < 64) ? c : ((c >= 70) ? c - 6 : 63);
`ifdef FX68K_RESET_STRETCH_EN
            exp_ext = (c >= 64) && (c <= 82);
`else
            exp_ext = (c == 64);
`endif
            if (c >= 64 && c <= 69) begin
                exp = {exp_ext, 1'b0, 1'b0, 1'b0};
            end else begin
                exp = {exp_ext, 1'b0, (t % 4) == 0, (t % 4) == 2};
            end
            exp_ph = (t % 4) >= 2;
            checks++;
            if (obs_a !== exp || phase_a !== exp_ph) begin
                errors++;
                $display("FAIL req_stall cycle %0d got clks=%b phase=%b expected clks=%b phase=%b", c, obs_a, phase_a, exp, exp_ph);
            end
            stall_a = (c + 1 >= 64) && (c + 1 <= 69);
            req_a = (c + 1 == 64);
        end
    endtask

    // Continues from cycle 86: async reset while stalled with a request in flight.
    task automatic test_async_reset_mid_stretch;
        logic [3:0] exp;
        stall_a = 1'b1;
        req_a = 1'b1;
        tick;
        checks++;
        if (obs_a[3] !== 1'b1 || obs_a[2] !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_rise got ext=%b pwrup=%b expected ext=1 pwrup=0", obs_a[3], obs_a[2]);
        end
        req_a = 1'b0;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_a !== 4'b1100 || phase_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got clks=%b phase=%b expected clks=1100 phase=0", obs_a, phase_a);
        end
        stall_a = 1'b0;
        tick;
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            exp = {1'b1, 1'b1, (c % 4) == 0, (c % 4) == 2};
            checks++;
            if (obs_a !== exp || phase_a !== ((c >= 2) && ((c % 4) >= 2))) begin
                errors++;
                $display("FAIL restart cycle %0d got clks=%b phase=%b expected clks=%b", c, obs_a, phase_a, exp);
            end
        end
    endtask

    task automatic test_powerup_with_request;
        logic [3:0] exp;
        logic       exp_ext;
        do_reset;
        req_a = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            tick;
`ifdef FX68K_RESET_STRETCH_EN
            exp_ext = (c <= 48);
`else
            exp_ext = (c <= 35);
`endif
            exp = {exp_ext, c < 33, (c % 4) == 0, (c % 4) == 2};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL powerup_req cycle %0d got clks=%b expected clks=%b", c, obs_a, exp);
            end
            req_a = (c + 1 <= 35);
        end
    endtask

    task automatic test_stall;
        logic [3:0] exp;
        logic       exp_ph;
        int         t;
        int         n1;
        int         n2;
        n1 = 0;
        n2 = 0;
        do_reset;
        for (int c = 1; c <= 65; c++) begin
            tick;
            t = (c <= 7) ? ((c <= 2) ? c : 2) : c - 5;
            exp = {1'b1, 1'b1, (t % 6) == 0 && t > 0, (t % 6) == 3};
            exp_ph = (t >= 3) && ((t % 6) >= 3);
            checks++;
            if (obs_b !== exp || phase_b !== exp_ph) begin
                errors++;
                $display("FAIL stall cycle %0d got clks=%b phase=%b expected clks=%b phase=%b", c, obs_b, phase_b, exp, exp_ph);
            end
            if (obs_b[1]) n1++;
            if (obs_b[0]) n2++;
            stall_b = (c + 1 >= 3) && (c + 1 <= 7);
        end
        checks++;
        if (n1 != 10 || n2 != 10) begin
            errors++;
            $display("FAIL stall_pulse_count got phi1=%0d phi2=%0d expected phi1=10 phi2=10", n1, n2);
        end
    endtask

    initial begin
        test_reset;
        test_powerup;
        test_reset_request;
        test_req_stall;
        test_async_reset_mid_stretch;
        test_powerup_with_request;
        test_stall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
